// File: rtl/keypad_scanner_pkg.sv
// Shared definitions for the 4x4 keypad scanner: column strobe patterns,
// key-code map and FSM state encoding.
package keypad_scanner_pkg;

    // Active-low column strobes indexed by column number
    localparam logic [3:0] COL_PATTERN [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

    // Key code indexed by {row, col}: r0=1,2,3,A r1=4,5,6,B r2=7,8,9,C r3=E,0,F,D
    localparam logic [3:0] KEY_MAP [16] = '{
        4'h1, 4'h2, 4'h3, 4'hA,
        4'h4, 4'h5, 4'h6, 4'hB,
        4'h7, 4'h8, 4'h9, 4'hC,
        4'hE, 4'h0, 4'hF, 4'hD
    };

    typedef enum logic [1:0] {
        IDLE,
        DEBOUNCE,
        PRESSED,
        RELEASE
    } key_state_e;

endpackage

// File: rtl/keypad_scanner_tick.sv
// Column scan timebase: prescaler producing one tick every SCAN_DIV cycles,
// column index rotation 0..3 and the registered active-low column strobes.
module keypad_scan_tick
    import keypad_scanner_pkg::*;
#(
    parameter int unsigned SCAN_DIV = 50000
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    output logic       tick_o,
    output logic [1:0] col_idx_o,
    output logic [3:0] col_o
);

    localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);

    logic [PW-1:0] presc_q, presc_d;
    logic [1:0]    col_idx_q, col_idx_d;
    logic [3:0]    col_q, col_d;
    logic          tick;

    assign tick = (presc_q == PRESC_LAST);

    // Next-state: prescaler wraps on tick, column advances on the same tick
    always_comb begin
        presc_d   = tick ? '0 : presc_q + 1'b1;
        col_idx_d = col_idx_q;
        col_d     = col_q;
        if (tick) begin
            col_idx_d = col_idx_q + 2'd1;
            col_d     = COL_PATTERN[col_idx_d];
        end
    end

    // Timebase registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            presc_q   <= '0;
            col_idx_q <= '0;
            col_q     <= 4'b1110;
        end else begin
            presc_q   <= presc_d;
            col_idx_q <= col_idx_d;
            col_q     <= col_d;
        end
    end

    assign tick_o    = tick;
    assign col_idx_o = col_idx_q;
    assign col_o     = col_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner with debounce and single-key acceptance.
// Optional key history shift register enabled by defining KEYPAD_HISTORY_EN.
module keypad_scanner
    import keypad_scanner_pkg::*;
#(
    parameter int unsigned SCAN_DIV       = 50000,
    parameter int unsigned DEBOUNCE_SCANS = 4
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [3:0]  Row,
    output logic [3:0]  Col,
    output logic [3:0]  KeyCode,
    output logic        KeyValid,
    output logic        KeyDown
`ifdef KEYPAD_HISTORY_EN
    ,
    output logic [15:0] History
`endif
);

    localparam int unsigned CW = (DEBOUNCE_SCANS > 0) ? $clog2(DEBOUNCE_SCANS + 1) : 1;
    localparam logic [CW-1:0] DS_C = CW'(DEBOUNCE_SCANS);

    logic        tick;
    logic [1:0]  col_idx;
    logic [3:0]  row_meta_q, row_sync_q;
    logic [15:0] image_q, image_d;
    logic [4:0]  n_pressed;
    logic [3:0]  scan_code;
    logic        is_one, scan_done;

    key_state_e  state_q;
    logic [3:0]  cand_q, key_code_q;
    logic [CW-1:0] cnt_q, cnt_inc;
    logic        key_valid_q, key_down_q;

    keypad_scan_tick #(
        .SCAN_DIV (SCAN_DIV)
    ) u_tick (
        .clk_i     (CLK),
        .rst_ni    (RST_N),
        .tick_o    (tick),
        .col_idx_o (col_idx),
        .col_o     (Col)
    );

    // Two-flop synchronizer for the asynchronous row inputs (idle rows read high)
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            row_meta_q <= '1;
            row_sync_q <= '1;
        end else begin
            row_meta_q <= Row;
            row_sync_q <= row_meta_q;
        end
    end

    // Scan image: bit {col,row} holds the sampled active-low row for that column
    always_comb begin
        image_d = image_q;
        if (tick) begin
            image_d[{col_idx, 2'b00} +: 4] = row_sync_q;
        end
    end

    // Scan image register; fully rewritten before the first classification
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) image_q <= '0;
        else        image_q <= image_d;
    end

    // Classify the image as it will stand after this tick (includes column 3)
    always_comb begin
        logic [3:0] idx;
        n_pressed = '0;
        scan_code = '0;
        for (int unsigned i = 0; i < 16; i++) begin
            idx = 4'(i);
            if (!image_d[idx]) begin
                n_pressed = n_pressed + 5'd1;
                scan_code = KEY_MAP[{idx[1:0], idx[3:2]}];
            end
        end
    end

    assign is_one    = (n_pressed == 5'd1);
    assign scan_done = tick && (col_idx == 2'd3);
    assign cnt_inc   = (cnt_q == DS_C) ? cnt_q : cnt_q + 1'b1;

    // Debounce FSM, evaluated once per completed scan; outputs are registered
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= IDLE;
            cand_q      <= '0;
            cnt_q       <= '0;
            key_code_q  <= '0;
            key_valid_q <= 1'b0;
            key_down_q  <= 1'b0;
        end else begin
            key_valid_q <= 1'b0;
            if (scan_done) begin
                unique case (state_q)
                    IDLE: begin
                        if (is_one) begin
                            if (DEBOUNCE_SCANS <= 1) begin
                                state_q     <= PRESSED;
                                key_code_q  <= scan_code;
                                key_down_q  <= 1'b1;
                                key_valid_q <= 1'b1;
                                cnt_q       <= '0;
                            end else begin
                                state_q <= DEBOUNCE;
                                cand_q  <= scan_code;
                                cnt_q   <= CW'(1);
                            end
                        end
                    end
                    DEBOUNCE: begin
                        if (!is_one) begin
                            state_q <= IDLE;
                            cnt_q   <= '0;
                        end else if (scan_code == cand_q) begin
                            if (cnt_inc == DS_C) begin
                                state_q     <= PRESSED;
                                key_code_q  <= cand_q;
                                key_down_q  <= 1'b1;
                                key_valid_q <= 1'b1;
                                cnt_q       <= '0;
                            end else begin
                                cnt_q <= cnt_inc;
                            end
                        end else begin
                            cand_q <= scan_code;
                            cnt_q  <= CW'(1);
                        end
                    end
                    PRESSED: begin
                        if (!is_one) begin
                            if (DEBOUNCE_SCANS <= 1) begin
                                state_q    <= IDLE;
                                key_down_q <= 1'b0;
                                cnt_q      <= '0;
                            end else begin
                                state_q <= RELEASE;
                                cnt_q   <= CW'(1);
                            end
                        end
                    end
                    RELEASE: begin
                        if (is_one) begin
                            state_q <= PRESSED;
                            cnt_q   <= '0;
                        end else if (cnt_inc == DS_C) begin
                            state_q    <= IDLE;
                            key_down_q <= 1'b0;
                            cnt_q      <= '0;
                        end else begin
                            cnt_q <= cnt_inc;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign KeyCode  = key_code_q;
    assign KeyValid = key_valid_q;
    assign KeyDown  = key_down_q;

`ifdef KEYPAD_HISTORY_EN
    logic [15:0] history_q;

    // Shift each newly accepted key into the low nibble
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)           history_q <= '0;
        else if (key_valid_q) history_q <= {history_q[11:0], key_code_q};
    end

    assign History = history_q;
`endif

endmodule
